branch_resolve_unit: RTL and testbench

- Multicycle branch-condition resolver for the processor datapath. Generalises the 4-op BEQ/BNE/BLE/BGT flag selector to a parametrised width and 6 conditions.
- Compares two operands itself and reports the taken/not-taken decision to the control unit (UC) with a start/done handshake.
- Keeps a per-index 2-bit saturating predictor table, so UC can flag mispredicts.

---
 rtl/branch_resolve_unit.sv | 199 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Multicycle signed branch-condition resolver with a 2-bit saturating predictor table; BRANCH_STATS_EN builds stat counters.
// Latency: start sampled at edge N, done pulses in the cycle after edge N+2 (one accepted request per 3 cycles).
// Backpressure: start is accepted only while idle (busy=0); requests arriving while busy are dropped, not queued.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IDX_W-1:0]  pc_idx,
  output logic              busy,
  output logic              pred_taken,
  output logic              done,
  output logic              taken,
  output logic              mispredict,
  output logic              illegal_op,
  output logic [15:0]       stat_total,
  output logic [15:0]       stat_miss
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESOLVE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic              pred_taken_q, pred_taken_d;
  logic              taken_q, taken_d;
  logic              mispredict_q, mispredict_d;
  logic              illegal_op_q, illegal_op_d;
  logic              done_q, done_d;
  logic [1:0]        pred_tbl_q [DEPTH];
  logic [1:0]        pred_tbl_d [DEPTH];

  logic              legal;
  logic              cond;
  logic [1:0]        ctr_cur;
  logic [1:0]        ctr_next;
  logic              stat_upd;
  logic              stat_miss_upd;

  always_comb begin
    legal = (op_q[2:1] != 2'b11);
    case (op_q)
      3'b000:  cond = eq_q;
      3'b001:  cond = !eq_q;
      3'b010:  cond = eq_q | lt_q;
      3'b011:  cond = gt_q;
      3'b100:  cond = lt_q;
      3'b101:  cond = eq_q | gt_q;
      default: cond = 1'b0;
    endcase
    ctr_cur  = pred_tbl_q[idx_q];
    ctr_next = ctr_cur;
    if (cond && ctr_cur != 2'b11) begin
      ctr_next = ctr_cur + 2'd1;
    end else if (!cond && ctr_cur != 2'b00) begin
      ctr_next = ctr_cur - 2'd1;
    end
    stat_upd      = (state_q == S_RESOLVE) && legal;
    stat_miss_upd = stat_upd && (cond != pred_taken_q);
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    idx_d        = idx_q;
    eq_d         = eq_q;
    lt_d         = lt_q;
    gt_d         = gt_q;
    pred_taken_d = pred_taken_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_op_d = illegal_op_q;
    done_d       = 1'b0;
    pred_tbl_d   = pred_tbl_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d          = a;
          b_d          = b;
          op_d         = op;
          idx_d        = pc_idx;
          pred_taken_d = pred_tbl_q[pc_idx][1];
          state_d      = S_CMP;
        end
      end
      S_CMP: begin
        eq_d    = (a_q == b_q);
        lt_d    = ($signed(a_q) < $signed(b_q));
        gt_d    = !(a_q == b_q) && !($signed(a_q) < $signed(b_q));
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        // Illegal ops report a forced not-taken and leave the predictor untouched.
        taken_d      = legal & cond;
        mispredict_d = legal & (cond != pred_taken_q);
        illegal_op_d = !legal;
        done_d       = 1'b1;
        state_d      = S_IDLE;
        if (legal) begin
          pred_tbl_d[idx_q] = ctr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
      gt_q         <= 1'b0;
      pred_taken_q <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_op_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pred_tbl_q[i] <= 2'b01;
      end
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
      pred_taken_q <= pred_taken_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_op_q <= illegal_op_d;
      done_q       <= done_d;
      pred_tbl_q   <= pred_tbl_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_miss_q, stat_miss_d;

  always_comb begin
    stat_total_d = stat_total_q;
    stat_miss_d  = stat_miss_q;
    if (stat_upd && stat_total_q != 16'hFFFF) begin
      stat_total_d = stat_total_q + 16'd1;
    end
    if (stat_miss_upd && stat_miss_q != 16'hFFFF) begin
      stat_miss_d = stat_miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_miss_q  <= stat_miss_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_miss  = stat_miss_q;
`else
  logic unused_stat;
  assign unused_stat = stat_upd ^ stat_miss_upd;
  assign stat_total  = 16'd0;
  assign stat_miss   = 16'd0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign pred_taken = pred_taken_q;
  assign done       = done_q;
  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized requests against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  pc_idx = '0;
  logic        busy, pred_taken, done, taken, mispredict, illegal_op;
  logic [15:0] stat_total, stat_miss;

  int tests = 0;
  int fails = 0;

  // Behavioural model: counter value per table entry and resolve statistics.
  int pred_m [16];
  int stat_tot_m;
  int stat_miss_m;

  branch_resolve_unit #(.DATA_W(32), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .pc_idx(pc_idx),
    .busy(busy), .pred_taken(pred_taken), .done(done), .taken(taken),
    .mispredict(mispredict), .illegal_op(illegal_op),
    .stat_total(stat_total), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pred_m[i] = 1;
    stat_tot_m  = 0;
    stat_miss_m = 0;
  endtask

  task automatic model_resolve(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                               input logic [3:0] midx, output bit t, output bit p, output bit m, output bit il);
    int sa;
    int sb;
    sa = ma;
    sb = mb;
    p  = (pred_m[midx] >= 2);
    il = (mop >= 3'd6);
    case (mop)
      3'd0: t = (sa == sb);
      3'd1: t = (sa != sb);
      3'd2: t = (sa <= sb);
      3'd3: t = (sa > sb);
      3'd4: t = (sa < sb);
      3'd5: t = (sa >= sb);
      default: t = 1'b0;
    endcase
    m = il ? 1'b0 : (t != p);
    if (!il) begin
      if (t && pred_m[midx] < 3) pred_m[midx]++;
      if (!t && pred_m[midx] > 0) pred_m[midx]--;
      if (stat_tot_m < 65535) stat_tot_m++;
      if (m && stat_miss_m < 65535) stat_miss_m++;
    end
  endtask

  // Issues one request and waits (bounded) for done; optionally pokes start while busy.
  task automatic do_branch(input logic [2:0] bop, input logic [31:0] ba, input logic [31:0] bb,
                           input logic [3:0] bidx, input bit noise,
                           output bit got, output int lat, output bit busy_seen);
    start = 1'b1; op = bop; a = ba; b = bb; pc_idx = bidx;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (noise && c == 1) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; pc_idx = 4'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if ({taken, mispredict, illegal_op, pred_taken} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got=%b exp=0000", {taken, mispredict, illegal_op, pred_taken});
    end
    tests++; if ({stat_total, stat_miss} !== 32'd0) begin
      fails++; $display("FAIL reset_stats got=%h/%h exp=0/0", stat_total, stat_miss);
    end
  endtask

  task automatic test_predictor();
    bit got, bsy, t, p, m, il;
    int lat;
    for (int r = 0; r < 3; r++) begin
      model_resolve(3'd0, 32'd5, 32'd5, 4'd3, t, p, m, il);
      do_branch(3'd0, 32'd5, 32'd5, 4'd3, 1'b0, got, lat, bsy);
      tests++; if (bsy !== 1'b1) begin fails++; $display("FAIL pred_busy r=%0d got=%b exp=1", r, bsy); end
      tests++; if (!got || lat != 2) begin fails++; $display("FAIL pred_latency r=%0d got=%0d exp=2", r, lat); end
      tests++; if ({taken, pred_taken, mispredict} !== {t, p, m}) begin
        fails++; $display("FAIL pred_result r=%0d got=%b exp=%b", r, {taken, pred_taken, mispredict}, {t, p, m});
      end
      @(posedge clk); #1;
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse r=%0d got=%b exp=0", r, done); end
      tests++; if (taken !== t) begin fails++; $display("FAIL taken_hold r=%0d got=%b exp=%b", r, taken, t); end
    end
  endtask

  task automatic test_signed();
    logic [2:0]  sop [3] = '{3'd3, 3'd4, 3'd2};
    logic [31:0] sa  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] sb  [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    bit got, bsy, t, p, m, il;
    int lat;
    for (int k = 0; k < 3; k++) begin
      model_resolve(sop[k], sa[k], sb[k], 4'd9, t, p, m, il);
      do_branch(sop[k], sa[k], sb[k], 4'd9, 1'b0, got, lat, bsy);
      tests++; if (!got || taken !== t) begin
        fails++; $display("FAIL signed_%0d got=%b done=%b exp=%b", k, taken, got, t);
      end
    end
    model_resolve(3'd4, 32'h8000_0000, 32'h0000_0001, 4'd9, t, p, m, il);
    do_branch(3'd4, 32'h8000_0000, 32'h0000_0001, 4'd9, 1'b0, got, lat, bsy);
    tests++; if (!got || taken !== t) begin fails++; $display("FAIL signed_minint got=%b exp=%b", taken, t); end
  endtask

  task automatic test_illegal();
    bit got, bsy, t, p, m, il;
    int lat;
    logic [15:0] tot_before;
    for (int k = 6; k <= 7; k++) begin
      tot_before = stat_total;
      model_resolve(3'(k), 32'd5, 32'd5, 4'd3, t, p, m, il);
      do_branch(3'(k), 32'd5, 32'd5, 4'd3, 1'b0, got, lat, bsy);
      tests++; if (!got || {illegal_op, taken, mispredict} !== {il, t, m}) begin
        fails++; $display("FAIL illegal_%0d got=%b done=%b exp=%b", k, {illegal_op, taken, mispredict}, got, {il, t, m});
      end
      tests++; if (stat_total !== tot_before) begin
        fails++; $display("FAIL illegal_stat got=%0d exp=%0d", stat_total, tot_before);
      end
    end
    // Entry 3 must still be saturated-taken, and a legal op clears illegal_op.
    model_resolve(3'd1, 32'd5, 32'd5, 4'd3, t, p, m, il);
    do_branch(3'd1, 32'd5, 32'd5, 4'd3, 1'b0, got, lat, bsy);
    tests++; if ({pred_taken, taken, mispredict, illegal_op} !== {p, t, m, il}) begin
      fails++; $display("FAIL illegal_after got=%b exp=%b", {pred_taken, taken, mispredict, illegal_op}, {p, t, m, il});
    end
  endtask

  task automatic test_stats();
    int exp_tot;
    int exp_miss;
`ifdef BRANCH_STATS_EN
    exp_tot  = stat_tot_m;
    exp_miss = stat_miss_m;
`else
    exp_tot  = 0;
    exp_miss = 0;
`endif
    tests++; if (int'(stat_total) != exp_tot) begin fails++; $display("FAIL stat_total got=%0d exp=%0d", stat_total, exp_tot); end
    tests++; if (int'(stat_miss) != exp_miss) begin fails++; $display("FAIL stat_miss got=%0d exp=%0d", stat_miss, exp_miss); end
  endtask

  task automatic test_random();
    bit got, bsy, t, p, m, il;
    int lat;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [3:0]  ridx;
    bit noise;
    for (int n = 0; n < 60; n++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 8)) - 4);
      rb   = ($urandom_range(0, 3) == 0) ? ra : 32'($signed($urandom_range(0, 8)) - 4);
      ridx = 4'($urandom_range(0, 3));
      noise = ($urandom_range(0, 1) == 1);
      model_resolve(rop, ra, rb, ridx, t, p, m, il);
      do_branch(rop, ra, rb, ridx, noise, got, lat, bsy);
      tests++; if (!got || lat != 2 || {taken, pred_taken, mispredict, illegal_op} !== {t, p, m, il}) begin
        fails++;
        $display("FAIL random_%0d op=%0d a=%h b=%h idx=%0d got=%b lat=%0d exp=%b", n, rop, ra, rb, ridx,
                 {taken, pred_taken, mispredict, illegal_op}, lat, {t, p, m, il});
      end
    end
  endtask

  task automatic test_back_to_back();
    bit t, p, m, il;
    int ndone = 0;
    int first = -1;
    int last = -1;
    bit spacing_ok = 1'b1;
    start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; pc_idx = 4'd7;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 9) start = 1'b0;
      if (done) begin
        if (last >= 0 && c - last != 3) spacing_ok = 1'b0;
        if (first < 0) first = c;
        last = c;
        ndone++;
      end
    end
    for (int k = 0; k < 3; k++) model_resolve(3'd0, 32'd1, 32'd1, 4'd7, t, p, m, il);
    tests++; if (ndone != 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
    tests++; if (!spacing_ok || first != 3) begin
      fails++; $display("FAIL b2b_spacing first=%0d last=%0d exp first=3 last=9", first, last);
    end
  endtask

  task automatic test_reset_abort();
    bit got, bsy, t, p, m, il;
    int lat;
    int seen = 0;
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2; pc_idx = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_done got=%0d exp=0", seen); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < 2; r++) begin
        model_resolve(3'd0, 32'd0, 32'd0, 4'(i), t, p, m, il);
        do_branch(3'd0, 32'd0, 32'd0, 4'(i), 1'b0, got, lat, bsy);
        tests++; if (!got || pred_taken !== p) begin
          fails++; $display("FAIL abort_table idx=%0d r=%0d got=%b exp=%b", i, r, pred_taken, p);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_predictor();
    test_illegal();
    test_stats();
    test_signed();
    test_random();
    test_back_to_back();
    test_stats();
    test_reset_abort();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
